pipe_ctrl: RTL and testbench

Central pipeline sequencing controller for the 5-stage core. It merges load-use stall requests and sequences the multi-cycle divider through a start/wait/done handshake. It also redirects the front end on exceptions and ERET, owns the EPC register, and counts stalled cycles.
It sits beside IF/ID/EX/MEM/WB and drives their stall and flush inputs.

---
 rtl/pipe_ctrl.sv | 95 +++++++++
 tb/tb_pipe_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges load-use stalls, sequences the divider
// handshake, redirects the front end on exception/ERET, owns EPC and a stall counter.
module pipe_ctrl #(
  parameter int unsigned STALL_W    = 6,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter logic [31:0] RESET_EPC  = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_from_id,
  input  logic               ex_div_req,
  input  logic               div_done,
  input  logic               mem_excp,
  input  logic [31:0]        mem_excp_pc,
  input  logic               mem_eret,
  output logic [STALL_W-1:0] stall,
  output logic               div_start,
  output logic               div_annul,
  output logic               flush,
  output logic               new_pc_valid,
  output logic [31:0]        new_pc,
  output logic [31:0]        epc,
  output logic [31:0]        stall_cycles
);

  typedef enum logic [1:0] {IDLE, DIV_WAIT, FLUSH} state_t;

  localparam logic [STALL_W-1:0] STALL_DIV = STALL_W'(6'b001111);
  localparam logic [STALL_W-1:0] STALL_LU  = STALL_W'(6'b000111);

  state_t      state, state_nxt;
  logic [31:0] epc_q;
  logic [31:0] stall_cnt;

  // Redirects outrank everything in every state; reset gates all outputs low.
  always_comb begin
    state_nxt    = state;
    stall        = '0;
    div_start    = 1'b0;
    div_annul    = 1'b0;
    flush        = 1'b0;
    new_pc_valid = 1'b0;
    new_pc       = '0;
    if (rst) begin
      if (mem_excp || mem_eret) begin
        flush        = 1'b1;
        new_pc_valid = 1'b1;
        new_pc       = mem_excp ? EXC_VECTOR : epc_q;
        div_annul    = (state == DIV_WAIT);
        state_nxt    = FLUSH;
      end else begin
        unique case (state)
          IDLE: begin
            if (ex_div_req) begin
              div_start = 1'b1;
              stall     = STALL_DIV;
              state_nxt = DIV_WAIT;
            end else if (stallreq_from_id) begin
              stall = STALL_LU;
            end
          end
          DIV_WAIT: begin
            if (div_done) begin
              state_nxt = IDLE;
            end else begin
              stall = STALL_DIV;
            end
          end
          FLUSH: state_nxt = IDLE;
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      epc_q     <= RESET_EPC;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (mem_excp) begin
        epc_q <= mem_excp_pc;
      end
      if (stall != '0) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

  assign epc          = epc_q;
  assign stall_cycles = stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: each driven cycle pushes its expected outputs,
// which are popped and compared once the combinational outputs settle.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallreq_from_id = 1'b0;
  logic        ex_div_req = 1'b0;
  logic        div_done = 1'b0;
  logic        mem_excp = 1'b0;
  logic [31:0] mem_excp_pc = '0;
  logic        mem_eret = 1'b0;
  logic [5:0]  stall;
  logic        div_start, div_annul, flush, new_pc_valid;
  logic [31:0] new_pc, epc, stall_cycles;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [31:0] m_epc = 32'h0;
  logic [31:0] m_cnt = 32'h0;

  typedef struct {
    string       tag;
    logic [5:0]  stall;
    logic        ds, da, fl, npv;
    logic [31:0] npc, epc, cnt;
  } exp_t;

  exp_t sb[$];

  pipe_ctrl #(
    .STALL_W(6),
    .EXC_VECTOR(32'hBFC0_0380),
    .RESET_EPC(32'h0000_0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stallreq_from_id(stallreq_from_id),
    .ex_div_req(ex_div_req),
    .div_done(div_done),
    .mem_excp(mem_excp),
    .mem_excp_pc(mem_excp_pc),
    .mem_eret(mem_eret),
    .stall(stall),
    .div_start(div_start),
    .div_annul(div_annul),
    .flush(flush),
    .new_pc_valid(new_pc_valid),
    .new_pc(new_pc),
    .epc(epc),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic cyc(input string tag,
                     input logic sreq, input logic dreq, input logic done,
                     input logic excp, input logic [31:0] xpc, input logic eret,
                     input logic [5:0] e_stall, input logic e_ds, input logic e_da,
                     input logic e_fl, input logic e_npv, input logic [31:0] e_npc);
    exp_t e;
    @(negedge clk);
    stallreq_from_id = sreq;
    ex_div_req       = dreq;
    div_done         = done;
    mem_excp         = excp;
    mem_excp_pc      = xpc;
    mem_eret         = eret;
    e.tag = tag; e.stall = e_stall; e.ds = e_ds; e.da = e_da; e.fl = e_fl;
    e.npv = e_npv; e.npc = e_npc; e.epc = m_epc; e.cnt = m_cnt;
    sb.push_back(e);
    #2;
    e = sb.pop_front();
    check({e.tag, ".stall"}, 32'(stall), 32'(e.stall));
    check({e.tag, ".div_start"}, 32'(div_start), 32'(e.ds));
    check({e.tag, ".div_annul"}, 32'(div_annul), 32'(e.da));
    check({e.tag, ".flush"}, 32'(flush), 32'(e.fl));
    check({e.tag, ".new_pc_valid"}, 32'(new_pc_valid), 32'(e.npv));
    check({e.tag, ".new_pc"}, new_pc, e.npc);
    check({e.tag, ".epc"}, epc, e.epc);
    check({e.tag, ".stall_cycles"}, stall_cycles, e.cnt);
    // Model state that the coming clock edge will commit.
    if (e_stall != 6'b0) m_cnt = m_cnt + 32'd1;
    if (excp) m_epc = xpc;
  endtask

  localparam logic [5:0]  S0  = 6'b000000;
  localparam logic [5:0]  SLU = 6'b000111;
  localparam logic [5:0]  SDV = 6'b001111;
  localparam logic [31:0] EV  = 32'hBFC0_0380;
  localparam logic [31:0] Z   = 32'h0;

  initial begin
    #3;
    check("rst.stall", 32'(stall), 32'h0);
    check("rst.flush", 32'(flush), 32'h0);
    check("rst.epc", epc, 32'h0);
    check("rst.cnt", stall_cycles, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    //  tag       sreq dreq done excp pc            eret stall ds da fl npv new_pc
    cyc("lu",       1, 0, 0, 0, Z,             0, SLU, 0, 0, 0, 0, Z);
    cyc("lu_end",   0, 0, 0, 0, Z,             0, S0,  0, 0, 0, 0, Z);
    cyc("div0",     0, 1, 0, 0, Z,             0, SDV, 1, 0, 0, 0, Z);
    cyc("div1",     0, 1, 0, 0, Z,             0, SDV, 0, 0, 0, 0, Z);
    cyc("div2",     1, 1, 0, 0, Z,             0, SDV, 0, 0, 0, 0, Z);
    cyc("div3",     0, 1, 0, 0, Z,             0, SDV, 0, 0, 0, 0, Z);
    cyc("div_done", 0, 1, 1, 0, Z,             0, S0,  0, 0, 0, 0, Z);
    cyc("b2b0",     0, 1, 0, 0, Z,             0, SDV, 1, 0, 0, 0, Z);
    cyc("b2b1",     1, 1, 0, 0, Z,             0, SDV, 0, 0, 0, 0, Z);
    cyc("dv_excp",  0, 1, 1, 1, 32'hBFC0_1234, 0, S0,  0, 1, 1, 1, EV);
    cyc("flush0",   1, 1, 0, 0, Z,             0, S0,  0, 0, 0, 0, Z);
    cyc("eret",     0, 0, 0, 0, Z,             1, S0,  0, 0, 1, 1, 32'hBFC0_1234);
    cyc("flush1",   0, 1, 0, 0, Z,             0, S0,  0, 0, 0, 0, Z);
    cyc("exc_eret", 0, 0, 0, 1, 32'h0000_0400, 1, S0,  0, 0, 1, 1, EV);
    cyc("flush2",   0, 0, 0, 0, Z,             0, S0,  0, 0, 0, 0, Z);
    cyc("prio",     1, 1, 0, 0, Z,             0, SDV, 1, 0, 0, 0, Z);
    cyc("dwait",    0, 1, 0, 0, Z,             0, SDV, 0, 0, 0, 0, Z);

    // Asynchronous reset between edges while still in DIV_WAIT.
    @(negedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("arst.stall", 32'(stall), 32'h0);
    check("arst.div_start", 32'(div_start), 32'h0);
    check("arst.flush", 32'(flush), 32'h0);
    check("arst.div_annul", 32'(div_annul), 32'h0);
    check("arst.epc", epc, 32'h0);
    check("arst.cnt", stall_cycles, 32'h0);
    m_epc = 32'h0;
    m_cnt = 32'h0;
    ex_div_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cyc("post_rst", 0, 0, 0, 0, Z,             0, S0,  0, 0, 0, 0, Z);

    // Preload the counter at its ceiling to exercise the wrap.
    @(negedge clk);
    force dut.stall_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt;
    m_cnt = 32'hFFFF_FFFF;
    cyc("wrap",     1, 0, 0, 0, Z,             0, SLU, 0, 0, 0, 0, Z);
    cyc("wrapped",  0, 0, 0, 0, Z,             0, S0,  0, 0, 0, 0, Z);

    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
